// File: rtl/adc_frame_rx.sv
// adc_frame_rx: 8N1 UART deserialiser and 6-byte frame assembler with valid/ready result holding register
module adc_frame_rx #(
  parameter int OVERSAMPLE  = 8,
  parameter int FRAME_BYTES = 6,
  parameter int GAP_TIMEOUT = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        rx_pin,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [14:0] runup_cnt,
  output logic        rundown_sign,
  output logic [14:0] runup_set,
  output logic [15:0] rundown_cnt,
  output logic [47:0] frame_raw,
  output logic        err_reserved,
  output logic        err_framing,
  output logic        err_timeout,
  output logic        err_overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int FW = FRAME_BYTES * 8;
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta_q, rx_sync_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-9:0] frame_sh_q, frame_sh_d;
  logic [FW-1:0] hold_q, hold_d, new_frame;
  logic          valid_q, valid_d;
  logic          framing_q, timeout_q, overrun_q;
  logic          half_hit, full_hit, byte_done, framing, timeout, frame_done, load;

  assign half_hit = tick_en && tick_cnt_q == TW'(OVERSAMPLE / 2 - 1);
  assign full_hit = tick_en && tick_cnt_q == TW'(OVERSAMPLE - 1);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_en ? tick_cnt_q + 1'b1 : tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    framing    = 1'b0;
    case (state_q)
      S_IDLE: if (tick_en && !rx_sync_q) begin
        state_d    = S_START;
        tick_cnt_d = '0;
      end
      S_START: if (half_hit) begin
        state_d    = rx_sync_q ? S_IDLE : S_DATA;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      S_DATA: if (full_hit) begin
        shift_d   = {rx_sync_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        state_d   = bit_cnt_q == 3'd7 ? S_STOP : S_DATA;
      end
      S_STOP: if (full_hit) begin
        byte_done = rx_sync_q;
        framing   = !rx_sync_q;
        state_d   = rx_sync_q ? S_IDLE : S_BREAK;
      end
      S_BREAK: if (tick_en && rx_sync_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A byte landing on the timeout clock keeps the partial frame alive
  assign timeout    = tick_en && byte_idx_q != 3'd0 && gap_q == GW'(GAP_TIMEOUT - 1) && !byte_done;
  assign frame_done = byte_done && byte_idx_q == 3'(FRAME_BYTES - 1);
  assign new_frame  = {frame_sh_q, shift_q};
  assign load       = frame_done && (!valid_q || frame_ready);

  always_comb begin
    byte_idx_d = (framing || timeout || frame_done) ? 3'd0 : byte_done ? byte_idx_q + 3'd1 : byte_idx_q;
    gap_d      = (byte_done || framing || timeout || byte_idx_q == 3'd0) ? '0 :
                 (tick_en && gap_q != GW'(GAP_TIMEOUT)) ? gap_q + 1'b1 : gap_q;
    frame_sh_d = byte_done ? {frame_sh_q[FW-17:0], shift_q} : frame_sh_q;
    hold_d     = load ? new_frame : hold_q;
    valid_d    = load || (valid_q && !frame_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      gap_q      <= '0;
      frame_sh_q <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      framing_q  <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_pin;
      rx_sync_q  <= rx_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      gap_q      <= gap_d;
      frame_sh_q <= frame_sh_d;
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      framing_q  <= framing;
      timeout_q  <= timeout;
      overrun_q  <= frame_done && valid_q && !frame_ready;
    end
  end

  assign frame_valid  = valid_q;
  assign frame_raw    = hold_q;
  assign runup_cnt    = hold_q[46:32];
  assign rundown_sign = hold_q[31];
  assign runup_set    = hold_q[30:16];
  assign rundown_cnt  = hold_q[15:0];
  assign err_reserved = hold_q[47];
  assign err_framing  = framing_q;
  assign err_timeout  = timeout_q;
  assign err_overrun  = overrun_q;
endmodule

// File: tb/tb_adc_frame_rx.sv
// tb_adc_frame_rx: directed frame stimulus with hand-computed field values for adc_frame_rx
module tb_adc_frame_rx;
  logic        clk = 1'b0, rst = 1'b1, tick_en, rx_pin = 1'b1, frame_ready = 1'b1;
  logic        frame_valid, rundown_sign, err_reserved, err_framing, err_timeout, err_overrun;
  logic [14:0] runup_cnt, runup_set;
  logic [15:0] rundown_cnt;
  logic [47:0] frame_raw;
  logic [1:0]  tc = 2'd0;
  logic        v_prev = 1'b0;
  int n_chk = 0, n_err = 0;
  int n_fr = 0, n_to = 0, n_ov = 0, n_vhi = 0, n_drop = 0;
  int b_fr, b_to, b_ov, b_vhi, b_drop;

  adc_frame_rx dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .rx_pin(rx_pin),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .runup_cnt(runup_cnt), .rundown_sign(rundown_sign), .runup_set(runup_set),
    .rundown_cnt(rundown_cnt), .frame_raw(frame_raw), .err_reserved(err_reserved),
    .err_framing(err_framing), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tc <= tc + 2'd1;
  assign tick_en = tc == 2'd0;

  always @(posedge clk) begin
    n_fr   <= n_fr + int'(err_framing);
    n_to   <= n_to + int'(err_timeout);
    n_ov   <= n_ov + int'(err_overrun);
    n_vhi  <= n_vhi + int'(frame_valid);
    n_drop <= n_drop + int'(v_prev && !frame_valid);
    v_prev <= frame_valid;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap;
    b_fr = n_fr; b_to = n_to; b_ov = n_ov; b_vhi = n_vhi; b_drop = n_drop;
  endtask

  task automatic bit_out(input logic v);
    rx_pin = v;
    repeat (32) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask

  task automatic align;
    @(negedge clk);
    while (tc != 2'd1) @(negedge clk);
  endtask

  task automatic frame(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
    rx_pin = 1'b1;
  endtask

  task automatic fields(input string tag, input logic [14:0] ru, input logic sg,
                        input logic [14:0] rs, input logic [15:0] rd, input logic res);
    check({tag, "_runup"}, 48'(runup_cnt), 48'(ru));
    check({tag, "_sign"}, 48'(rundown_sign), 48'(sg));
    check({tag, "_set"}, 48'(runup_set), 48'(rs));
    check({tag, "_rundown"}, 48'(rundown_cnt), 48'(rd));
    check({tag, "_reserved"}, 48'(err_reserved), 48'(res));
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_valid", 48'(frame_valid), 48'd0);
    check("rst_raw", frame_raw, 48'd0);
    check("rst_errs", 48'({err_framing, err_timeout, err_overrun, err_reserved}), 48'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    snap();
    align();
    fork
      frame(48'h04D287CFBEEF);
      begin
        repeat (1907) @(negedge clk);
        check("t1_pre_valid", 48'(frame_valid), 48'd0);
        @(negedge clk);
        check("t1_rise_valid", 48'(frame_valid), 48'd1);
      end
    join
    fields("t1", 15'd1234, 1'b1, 15'd1999, 16'hBEEF, 1'b0);
    check("t1_raw", frame_raw, 48'h04D287CFBEEF);
    check("t1_valid_cycles", 48'(n_vhi - b_vhi), 48'd1);
    check("t1_errs", 48'((n_fr - b_fr) + (n_to - b_to) + (n_ov - b_ov)), 48'd0);

    snap();
    align();
    rx_pin = 1'b0;
    repeat (16) @(negedge clk);
    rx_pin = 1'b1;
    repeat (64) @(negedge clk);
    check("t2_errs", 48'((n_fr - b_fr) + (n_to - b_to) + (n_ov - b_ov)), 48'd0);
    check("t2_no_frame", 48'(n_vhi - b_vhi), 48'd0);

    snap();
    align();
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1);
    rx_pin = 1'b1;
    repeat (800) @(negedge clk);
    check("t3_timeout", 48'(n_to - b_to), 48'd1);
    check("t3_partial_dropped", 48'(n_vhi - b_vhi), 48'd0);
    align();
    frame(48'h00C800C70010);
    fields("t3", 15'd200, 1'b0, 15'd199, 16'd16, 1'b0);
    check("t3_timeout_once", 48'(n_to - b_to), 48'd1);

    snap();
    align();
    send_byte(8'h55, 1'b1); send_byte(8'hA5, 1'b0);
    rx_pin = 1'b1;
    repeat (64) @(negedge clk);
    check("t4_framing", 48'(n_fr - b_fr), 48'd1);
    check("t4_partial_dropped", 48'(n_vhi - b_vhi), 48'd0);
    align();
    frame(48'h123456789ABC);
    check("t4_raw", frame_raw, 48'h123456789ABC);
    fields("t4", 15'h1234, 1'b0, 15'h5678, 16'h9ABC, 1'b0);
    check("t4_no_timeout", 48'(n_to - b_to), 48'd0);

    frame_ready = 1'b0;
    snap();
    align();
    frame(48'h010203040506);
    check("t5_a_valid", 48'(frame_valid), 48'd1);
    check("t5_a_raw", frame_raw, 48'h010203040506);
    repeat (32) @(negedge clk);
    align();
    frame(48'h112233445566);
    check("t5_overrun", 48'(n_ov - b_ov), 48'd1);
    check("t5_held_raw", frame_raw, 48'h010203040506);
    check("t5_held_valid", 48'(frame_valid), 48'd1);
    snap();
    align();
    fork
      frame(48'h800000000001);
      begin
        repeat (1907) @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        check("t5_c_valid", 48'(frame_valid), 48'd1);
        check("t5_c_raw", frame_raw, 48'h800000000001);
        frame_ready = 1'b0;
      end
    join
    fields("t5", 15'd0, 1'b0, 15'd0, 16'd1, 1'b1);
    check("t5_c_no_overrun", 48'(n_ov - b_ov), 48'd0);
    check("t5_valid_never_dropped", 48'(n_drop - b_drop), 48'd0);

    align();
    send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1);
    bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_valid", 48'(frame_valid), 48'd0);
    check("t6_rst_raw", frame_raw, 48'd0);
    fields("t6_rst", 15'd0, 1'b0, 15'd0, 16'd0, 1'b0);
    rx_pin = 1'b1;
    frame_ready = 1'b1;
    rst = 1'b0;
    repeat (64) @(negedge clk);
    snap();
    align();
    frame(48'h7FFF8000FFFF);
    check("t6_raw", frame_raw, 48'h7FFF8000FFFF);
    fields("t6", 15'h7FFF, 1'b1, 15'd0, 16'hFFFF, 1'b0);
    check("t6_valid_cycles", 48'(n_vhi - b_vhi), 48'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
